// File: rtl/sort_pkg.sv
// Types and sizes shared between the sort feeder and the sorter array.
package sort_pkg;

    localparam int SORT_DATA_W  = 32;
    localparam int SORT_JOB_LEN = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered read data and a flush.
module sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;

    assign full  = count == CW'(FIFO_DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

    // Depth is a power of two, so the pointers wrap on overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (pop && !flush) begin
            rdata <= mem[rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/sort_feeder.sv
// Buffers the upstream word stream and issues one job of JOB_LEN
// words to the sorter, then holds func_sel through the drain window.
module sort_feeder
    import sort_pkg::*;
#(
    parameter int DATA_W       = SORT_DATA_W,
    parameter int JOB_LEN      = SORT_JOB_LEN,
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         acc_hold,
    output logic [DATA_W-1:0]            acc_data_o,
    output logic                         acc_data_valid,
    output logic                         func_sel,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(JOB_LEN+1)-1:0] issued_cnt
);

    localparam int CNT_W = $clog2(JOB_LEN + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(JOB_LEN);
    localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(DRAIN_CYCLES - 1);

    feed_state_t      state_q;
    feed_state_t      state_d;
    logic [CNT_W-1:0] accepted_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             kill;
    logic             job_on;

    assign kill = abort && (state_q != IDLE);

    assign in_ready = (state_q == LOAD) && !fifo_full
                    && (accepted_cnt < LAST_WORD);

    assign push = in_valid && in_ready && !kill;

    assign pop = (state_q == LOAD) && !fifo_empty && !acc_hold
               && (issued_cnt < LAST_WORD) && !kill;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (kill),
        .wdata (in_data),
        .rdata (acc_data_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (issued_cnt == LAST_WORD) state_d = DRAIN;
            DRAIN:   if (drain_cnt == LAST_DRN) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    assign job_on = (state_d == LOAD) || (state_d == DRAIN);

    // Status outputs are registered from the next state so they
    // line up with acc_data_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            accepted_cnt   <= '0;
            issued_cnt     <= '0;
            drain_cnt      <= '0;
            acc_data_valid <= 1'b0;
            func_sel       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_data_valid <= pop;
            func_sel       <= job_on;
            busy           <= job_on;
            done           <= state_d == DONE;
            if (kill || (state_q == IDLE && start)) begin
                accepted_cnt <= '0;
                issued_cnt   <= '0;
            end else begin
                if (push) accepted_cnt <= accepted_cnt + 1'b1;
                if (pop)  issued_cnt   <= issued_cnt + 1'b1;
            end
            if (state_q == DRAIN && state_d == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sort_feeder.sv
// Directed bench for sort_feeder with a queue-based job model.
module tb_sort_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        acc_hold = 1'b0;
    logic [31:0] acc_data_o;
    logic        acc_data_valid;
    logic        func_sel;
    logic        busy;
    logic        done;
    logic [3:0]  issued_cnt;

    sort_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .acc_hold       (acc_hold),
        .acc_data_o     (acc_data_o),
        .acc_data_valid (acc_data_valid),
        .func_sel       (func_sel),
        .busy           (busy),
        .done           (done),
        .issued_cnt     (issued_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int pcyc = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Job model: phase 0 idle, 1 load, 2 drain, 3 done.
    int          ph = 0;
    logic [31:0] mq[$];
    int          m_acc = 0;
    int          m_iss = 0;
    int          m_drn = 0;
    bit          e_valid = 0;
    logic [31:0] e_data = '0;

    function automatic bit m_rdy();
        return ph == 1 && mq.size() < 4 && m_acc < 10;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        bit can_pop;
        pcyc++;
        rdy = m_rdy();
        can_pop = ph == 1 && mq.size() > 0 && !acc_hold && m_iss < 10;
        if (rst) begin
            ph = 0; mq.delete(); m_acc = 0; m_iss = 0; m_drn = 0;
            e_valid = 0; e_data = '0;
        end else if (abort && ph != 0) begin
            ph = 0; mq.delete(); m_acc = 0; m_iss = 0; e_valid = 0;
        end else begin
            e_valid = 0;
            case (ph)
                0: if (start) begin ph = 1; m_acc = 0; m_iss = 0; end
                1: begin
                    if (m_iss == 10) begin
                        ph = 2; m_drn = 0;
                    end
                    if (can_pop) begin
                        e_data = mq.pop_front(); e_valid = 1; m_iss++;
                    end
                    if (in_valid && rdy) begin
                        mq.push_back(in_data); m_acc++;
                    end
                end
                2: if (m_drn == 11) ph = 3; else m_drn++;
                default: ph = 0;
            endcase
        end
    end

    logic [31:0] vlog[$];
    int          vcyc[$];
    int          acyc[$];
    int          done_n = 0;
    int          fs_after = 0;
    int          stall_n = 0;

    always @(negedge clk) begin
        chk("acc_data_valid", 32'(acc_data_valid), 32'(e_valid));
        chk("acc_data_o", acc_data_o, e_data);
        chk("func_sel", 32'(func_sel), 32'(ph == 1 || ph == 2));
        chk("busy", 32'(busy), 32'(ph == 1 || ph == 2));
        chk("done", 32'(done), 32'(ph == 3));
        chk("in_ready", 32'(in_ready), 32'(m_rdy()));
        chk("issued_cnt", 32'(issued_cnt), 32'(m_iss));
        if (acc_data_valid) begin
            vlog.push_back(acc_data_o);
            vcyc.push_back(pcyc);
        end else if (func_sel && vlog.size() >= 10) begin
            fs_after++;
        end
        if (done) done_n++;
        if (func_sel && !in_ready && acyc.size() < 10 && issued_cnt < 10)
            stall_n++;
    end

    logic [31:0] src[$];
    bit          en = 0;

    task automatic step();
        bit hs;
        in_valid = en && src.size() > 0;
        in_data  = in_valid ? src[0] : '0;
        #1;
        hs = in_valid && in_ready && !abort;
        if (hs) acyc.push_back(pcyc);
        @(negedge clk);
        #1;
        if (hs) void'(src.pop_front());
    endtask

    task automatic clear_logs();
        vlog.delete(); vcyc.delete(); acyc.delete();
        done_n = 0; fs_after = 0; stall_n = 0;
    endtask

    task automatic load_src(int base, int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(32'(base + i));
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic run_to_done(string name, int budget);
        int k = 0;
        while (done_n == 0 && k < budget) begin
            step(); k++;
        end
        if (done_n == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timeout after %0d cycles", name, budget);
        end
        step(); step();
    endtask

    function automatic int seq_err(int base);
        int e = 0;
        if (vlog.size() != 10) return 100 + vlog.size();
        for (int i = 0; i < 10; i++) if (vlog[i] != 32'(base + i)) e++;
        return e;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int k;
        bit pulsed;
        // reset
        rst = 1; step(); step();
        chk("reset_outputs",
            {acc_data_o[27:0], acc_data_valid, func_sel, busy, done},
            32'h0);
        chk("reset_ready_cnt", {27'h0, in_ready, issued_cnt}, 32'h0);
        rst = 0; step();

        // basic job
        clear_logs(); load_src(1, 10); en = 1;
        pulse_start();
        run_to_done("basic_done", 60);
        chk("basic_order", 32'(seq_err(1)), 0);
        chk("basic_latency",
            (vcyc.size() > 0 && acyc.size() > 0) ? 32'(vcyc[0] - acyc[0]) : '1,
            2);
        chk("basic_back2back",
            vcyc.size() == 10 ? 32'(vcyc[9] - vcyc[0]) : '1, 9);
        chk("basic_drain_cycles", 32'(fs_after), 12);
        chk("basic_done_once", 32'(done_n), 1);
        chk("basic_issued", 32'(issued_cnt), 10);

        // backpressure
        clear_logs(); load_src(101, 10); en = 0;
        pulse_start();
        k = 0;
        while (done_n == 0 && k < 150) begin
            acc_hold = (k >= 4 && k < 9);
            en = acc_hold ? 1'b1 : (k % 2 == 0);
            step(); k++;
        end
        acc_hold = 0; en = 1;
        run_to_done("bp_done", 10);
        chk("bp_order", 32'(seq_err(101)), 0);
        chk("bp_count", 32'(vlog.size()), 10);
        chk("bp_ready_dropped", 32'(stall_n > 0), 1);

        // over-supply plus a start pulse during drain
        clear_logs(); load_src(201, 15); en = 1;
        pulse_start();
        k = 0; pulsed = 0;
        while (done_n == 0 && k < 80) begin
            start = !pulsed && func_sel && issued_cnt == 10 && !acc_data_valid;
            if (start) pulsed = 1;
            step(); start = 0; k++;
        end
        run_to_done("over_done", 5);
        chk("over_accepted", 32'(acyc.size()), 10);
        chk("over_left_upstream", 32'(src.size()), 5);
        chk("over_order", 32'(seq_err(201)), 0);
        chk("over_start_pulsed", 32'(pulsed), 1);
        chk("over_done_once", 32'(done_n), 1);

        // abort after 6 issued words
        clear_logs(); load_src(301, 10); en = 1;
        pulse_start();
        k = 0;
        while (vlog.size() < 6 && k < 40) begin step(); k++; end
        chk("abort_reached6", 32'(issued_cnt), 6);
        en = 0; abort = 1; step(); abort = 0;
        chk("abort_idle", {29'h0, func_sel, busy, acc_data_valid}, 32'h0);
        step(); step(); step();
        chk("abort_no_done", 32'(done_n), 0);
        clear_logs(); load_src(401, 10); en = 1;
        pulse_start();
        run_to_done("fresh_done", 60);
        chk("fresh_order", 32'(seq_err(401)), 0);

        // reset mid-job
        clear_logs(); load_src(501, 10); en = 1;
        pulse_start();
        step(); step(); step(); step();
        rst = 1; step(); rst = 0;
        chk("rst_mid_outputs",
            {acc_data_o[27:0], acc_data_valid, func_sel, busy, done},
            32'h0);
        chk("rst_mid_ready_cnt", {27'h0, in_ready, issued_cnt}, 32'h0);
        en = 0; step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
